instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Upstream neighbour of the decode stage. Owns the program counter and issues requests to instruction memory.
- Latches returned instructions into the IF/ID register: IF_ID_IR, IF_ID_NPC, IF_ID_PC and IF_ID_valid feed decode directly.
- Handles a variable-latency memory handshake, stall back-pressure from downstream, and branch/jump redirect with flush.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
NOP_INSTR  32'h0000_0013  instruction driven on IF_ID_IR when flushed/reset (addi x0,x0,0)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  decode/hazard stall; IF/ID must hold contents
branch_taken  input  1  one-cycle redirect pulse from execute
branch_target  input  32  redirect PC; bits [1:0] ignored (forced 0)
imem_req  output  1  instruction memory request valid
imem_addr  output  32  word-aligned fetch address
imem_ack  input  1  memory response valid (1+ cycles after req)
imem_rdata  input  32  instruction word, valid when imem_ack=1
IF_ID_IR  output  32  fetched instruction to decode
IF_ID_NPC  output  32  PC+4 of IF_ID_IR
IF_ID_PC  output  32  PC of IF_ID_IR
IF_ID_valid  output  1  IF_ID_IR is a real instruction (0 = bubble)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, IF_ID_IR=NOP_INSTR, IF_ID_NPC=0, IF_ID_PC=0, IF_ID_valid=0, hold buffer empty, drain flag clear. Reset mid-request abandons it; any later stray ack is ignored while IDLE.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: imem_req=0. Next cycle moves to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - req and addr are held stable until imem_ack.
  - On ack with stall=0: IF_ID_IR=rdata, IF_ID_PC=pc, IF_ID_NPC=pc+4, IF_ID_valid=1, pc=pc+4; stay in FETCH. The next request issues the following cycle.
  - Throughput with a 1-cycle-ack memory is one instruction per cycle.
  - On ack with stall=1: rdata/pc go into the hold buffer, pc=pc+4, go to HOLD. IF/ID is unchanged.
- HOLD: imem_req=0. While stall=1, IF/ID and the buffer hold. When stall=0, the buffer moves to IF/ID with valid=1, then go to FETCH.
- Bubble rule: in any cycle with stall=0 and no instruction delivered, IF_ID_valid<=0. IF_ID_IR/NPC/PC keep their old values.
- Stall: while stall=1, all IF_ID_* outputs are frozen, including IF_ID_valid.
- Branch redirect (branch_taken=1): highest priority, overrides stall.
  - pc=branch_target & ~3.
  - IF_ID_valid=0 and IF_ID_IR=NOP_INSTR (flush).
  - Hold buffer is discarded.
  - If state=FETCH and imem_ack=0 that cycle: go to DRAIN. imem_req stays at the old address until ack; that data is discarded; then go to FETCH at the target.
  - If imem_ack=1 in the same cycle: discard rdata, go straight to FETCH at the target.
  - From IDLE/HOLD: go to FETCH at the target.
  - A second branch_taken during DRAIN updates the target only.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no exception.
- Latency: from a request with ack in the same cycle as req, IF_ID is updated at that edge. With ack after N wait cycles, IF/ID is updated at the ack edge.

Test Plan:
- Reset then 1-cycle-ack memory returning 0xA,0xB,0xC -> IF_ID_PC 0,4,8 on consecutive cycles; NPC 4,8,12; valid=1 each cycle.
- Memory acks after 3 cycles -> imem_addr stable for 3 cycles; IF_ID_valid=0 for 2 bubble cycles then 1 with correct IR.
- Ack arrives while stall=1 for 4 cycles -> IF/ID frozen, imem_req=0 during HOLD; buffered IR appears one cycle after stall drops; PC sequence has no skip or repeat.
- branch_taken with target 0x103 while a request to 0x20 is outstanding -> IF_ID_valid=0, IR=0x13; 0x20 data is discarded; next imem_addr=0x100.
- branch_taken and stall together -> flush wins: IF_ID_valid=0, pc=target.
- pc=0xFFFF_FFFC fetch -> IF_ID_NPC=0, next imem_addr=0; rst asserted mid-request -> all outputs at reset values the next cycle, imem_req=0 for one cycle.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, runs the instruction-memory
// handshake, and fills the IF/ID register consumed by decode.
// Handles stall back-pressure through a one-entry hold buffer. Branch
// redirects flush IF/ID and drain any request that is still outstanding.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_IR,
    output logic [31:0] IF_ID_NPC,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic        imem_req_r, imem_req_s;
    logic [31:0] imem_addr_r, imem_addr_s;
    logic [31:0] if_id_ir_r, if_id_ir_s;
    logic [31:0] if_id_npc_r, if_id_npc_s;
    logic [31:0] if_id_pc_r, if_id_pc_s;
    logic        if_id_valid_r, if_id_valid_s;
    logic [31:0] hold_ir_r, hold_ir_s;
    logic [31:0] hold_pc_r, hold_pc_s;
    logic        hold_valid_r, hold_valid_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign target_s   = {branch_target[31:2], 2'b00};

    // Next state, next PC and hold-buffer update; redirect always wins.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        hold_ir_s    = hold_ir_r;
        hold_pc_s    = hold_pc_r;
        hold_valid_s = hold_valid_r;
        case (state_r)
            IDLE: begin
                if (branch_taken) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
                state_s = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    pc_s         = target_s;
                    hold_valid_s = 1'b0;
                    // An unacknowledged request must still complete before redirecting.
                    if (imem_ack) begin
                        state_s = FETCH;
                    end else begin
                        state_s = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_s = pc_plus4_s;
                    if (stall) begin
                        hold_ir_s    = imem_rdata;
                        hold_pc_s    = pc_r;
                        hold_valid_s = 1'b1;
                        state_s      = HOLD;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = FETCH;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_s         = target_s;
                    hold_valid_s = 1'b0;
                    state_s      = FETCH;
                end else if (!stall) begin
                    hold_valid_s = 1'b0;
                    state_s      = FETCH;
                end else begin
                    state_s = HOLD;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_ack) begin
                    state_s = FETCH;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s      = IDLE;
                hold_valid_s = 1'b0;
            end
        endcase
    end

    // Memory request for the coming cycle; DRAIN keeps the stale address until it is acked.
    always_comb begin
        imem_req_s = (state_s == FETCH) || (state_s == DRAIN);
        if (state_s == DRAIN) begin
            imem_addr_s = imem_addr_r;
        end else begin
            imem_addr_s = pc_s;
        end
    end

    // IF/ID update: flush, then freeze on stall, then deliver or insert a bubble.
    always_comb begin
        if_id_ir_s    = if_id_ir_r;
        if_id_npc_s   = if_id_npc_r;
        if_id_pc_s    = if_id_pc_r;
        if_id_valid_s = if_id_valid_r;
        if (branch_taken) begin
            if_id_ir_s    = NOP_INSTR;
            if_id_valid_s = 1'b0;
        end else if (stall) begin
            if_id_valid_s = if_id_valid_r;
        end else if ((state_r == FETCH) && imem_ack) begin
            if_id_ir_s    = imem_rdata;
            if_id_pc_s    = pc_r;
            if_id_npc_s   = pc_plus4_s;
            if_id_valid_s = 1'b1;
        end else if ((state_r == HOLD) && hold_valid_r) begin
            if_id_ir_s    = hold_ir_r;
            if_id_pc_s    = hold_pc_r;
            if_id_npc_s   = hold_pc_r + 32'd4;
            if_id_valid_s = 1'b1;
        end else begin
            if_id_valid_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= RESET_PC;
            if_id_ir_r    <= NOP_INSTR;
            if_id_npc_r   <= 32'd0;
            if_id_pc_r    <= 32'd0;
            if_id_valid_r <= 1'b0;
            hold_ir_r     <= NOP_INSTR;
            hold_pc_r     <= 32'd0;
            hold_valid_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            imem_req_r    <= imem_req_s;
            imem_addr_r   <= imem_addr_s;
            if_id_ir_r    <= if_id_ir_s;
            if_id_npc_r   <= if_id_npc_s;
            if_id_pc_r    <= if_id_pc_s;
            if_id_valid_r <= if_id_valid_s;
            hold_ir_r     <= hold_ir_s;
            hold_pc_r     <= hold_pc_s;
            hold_valid_r  <= hold_valid_s;
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign IF_ID_IR    = if_id_ir_r;
    assign IF_ID_NPC   = if_id_npc_r;
    assign IF_ID_PC    = if_id_pc_r;
    assign IF_ID_valid = if_id_valid_r;

endmodule
